// File: rtl/dpram_loader_pkg.sv
// Shared types and constants for the ioctl-to-dpram loader.
package dpram_loader_pkg;

   localparam int MAX_BYTES = 4;
   localparam int IOCTL_AW  = 25;
   localparam int LANE_W    = $clog2(MAX_BYTES);

   typedef enum logic [2:0] {
      IDLE,
      COLLECT,
      WRITE,
      FLUSH,
      DONE
   } state_e;

endpackage

// File: rtl/dpram_loader_if.sv
// HPS ioctl download stream plus one dpram write port; master drives ioctl, slave is the loader.
interface dpram_loader_if
   import dpram_loader_pkg::*;
#(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8
);

   logic                  ioctl_download;
   logic [7:0]            ioctl_index;
   logic                  ioctl_wr;
   logic [IOCTL_AW-1:0]   ioctl_addr;
   logic [7:0]            ioctl_dout;
   logic                  ioctl_wait;
   logic                  ram_enable;
   logic                  ram_wren;
   logic [ADDR_WIDTH-1:0] ram_address;
   logic [DATA_WIDTH-1:0] ram_data;

   modport master (
      output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
      input  ioctl_wait, ram_enable, ram_wren, ram_address, ram_data
   );

   modport slave (
      input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
      output ioctl_wait, ram_enable, ram_wren, ram_address, ram_data
   );

endinterface

// File: rtl/dpram_loader_byte_lane_packer.sv
// byte_lane_packer: assembles bytes into one RAM word; lanes never written stay 0x00.
module byte_lane_packer
   import dpram_loader_pkg::*;
#(
   parameter int BYTES = 1
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               clear,
   input  logic               store,
   input  logic [LANE_W-1:0]  lane,
   input  logic [7:0]         din,
   output logic [8*BYTES-1:0] word_data,
   output logic               partial,
   output logic               would_fill
);

   logic [BYTES-1:0][7:0] data_q, data_d;
   logic [BYTES-1:0]      mask_q, mask_d;
   logic [BYTES-1:0]      lane_hot;

   always_comb begin
      lane_hot = '0;
      for (int k = 0; k < BYTES; k++) lane_hot[k] = (lane == LANE_W'(k));
   end

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      data_d = data_q;
      mask_d = mask_q;
      if (clear) begin
         data_d = '0;
         mask_d = '0;
      end else if (store) begin
         for (int k = 0; k < BYTES; k++) begin
            if (lane_hot[k]) begin
               data_d[k] = din;
               mask_d[k] = 1'b1;
            end
         end
      end
   end

   // NOTE: the lane store is reset so a load aborted by reset can never leak stale bytes.
   always_ff @(posedge clock) begin
      if (reset) begin
         data_q <= '0;
         mask_q <= '0;
      end else begin
         data_q <= data_d;
         mask_q <= mask_d;
      end
   end

   assign word_data  = data_q;
   assign partial    = (|mask_q) && !(&mask_q);
   assign would_fill = &(mask_q | lane_hot);

endmodule

// File: rtl/dpram_loader.sv
// dpram_loader: filters the ioctl download by index and byte window, packs bytes into words and
// drives one dpram write port. Define DPRAM_LOADER_CHECKSUM_EN for the additive byte checksum.
module dpram_loader
   import dpram_loader_pkg::*;
#(
   parameter int                  ADDR_WIDTH = 8,
   parameter int                  DATA_WIDTH = 8,
   parameter logic [IOCTL_AW-1:0] BASE_ADDR  = '0,
   parameter logic [7:0]          INDEX      = 8'd0
) (
   input  logic          clock,
   input  logic          reset,
   dpram_loader_if.slave bus,
   output logic          done,
   output logic [7:0]    checksum
);

   localparam int BYTES = DATA_WIDTH / 8;
   localparam logic [IOCTL_AW:0] WIN_LO = {1'b0, BASE_ADDR};
   localparam logic [IOCTL_AW:0] WIN_HI = WIN_LO + (IOCTL_AW+1)'(BYTES * (2 ** ADDR_WIDTH));

   state_e                state_q, state_d;
   logic                  dl_q, dl_d, end_q, end_d;
   logic                  pend_valid_q, pend_valid_d;
   logic [ADDR_WIDTH-1:0] pend_word_q, pend_word_d, word_q, word_d;
   logic [LANE_W-1:0]     pend_lane_q, pend_lane_d;
   logic [7:0]            pend_data_q, pend_data_d;

   logic                  in_win, match, rise, fall, acc_live, take_live;
   logic [31:0]           off;
   logic [ADDR_WIDTH-1:0] word_live, src_word;
   logic [LANE_W-1:0]     lane_live, src_lane;
   logic [7:0]            src_data;
   logic                  src_valid, pk_clear, pk_store, pk_partial, pk_would_fill;
   logic [DATA_WIDTH-1:0] pk_data;
   logic                  ram_write, enter_collect;

   assign in_win    = ({1'b0, bus.ioctl_addr} >= WIN_LO) && ({1'b0, bus.ioctl_addr} < WIN_HI);
   assign off       = 32'(bus.ioctl_addr - BASE_ADDR);
   assign word_live = ADDR_WIDTH'(off / BYTES);
   assign lane_live = LANE_W'(off % BYTES);
   assign match     = (bus.ioctl_index == INDEX);
   assign dl_d      = bus.ioctl_download;
   assign rise      = bus.ioctl_download & ~dl_q & match;
   assign fall      = dl_q & ~bus.ioctl_download;
   // dl_q keeps a strobe coincident with the download fall acceptable.
   assign acc_live  = bus.ioctl_wr & (bus.ioctl_download | dl_q) & match & in_win;

   // A held byte always takes priority over the live strobe.
   assign src_valid = pend_valid_q | acc_live;
   assign src_word  = pend_valid_q ? pend_word_q : word_live;
   assign src_lane  = pend_valid_q ? pend_lane_q : lane_live;
   assign src_data  = pend_valid_q ? pend_data_q : bus.ioctl_dout;

   byte_lane_packer #(.BYTES(BYTES)) u_packer (
      .clock      (clock),
      .reset      (reset),
      .clear      (pk_clear),
      .store      (pk_store),
      .lane       (src_lane),
      .din        (src_data),
      .word_data  (pk_data),
      .partial    (pk_partial),
      .would_fill (pk_would_fill)
   );

   always_comb begin
      state_d       = state_q;
      end_d         = end_q | fall;
      pend_valid_d  = pend_valid_q;
      pend_word_d   = pend_word_q;
      pend_lane_d   = pend_lane_q;
      pend_data_d   = pend_data_q;
      word_d        = word_q;
      take_live     = 1'b0;
      pk_clear      = 1'b0;
      pk_store      = 1'b0;
      ram_write     = 1'b0;
      enter_collect = 1'b0;
      unique case (state_q)
         IDLE, DONE: begin
            end_d = 1'b0;
            if (rise) begin
               state_d       = COLLECT;
               enter_collect = 1'b1;
               pk_clear      = 1'b1;
               take_live     = acc_live;
            end
         end
         COLLECT: begin
            if (src_valid) begin
               if (pk_partial && (src_word != word_q)) begin
                  state_d   = WRITE;
                  take_live = acc_live && !pend_valid_q;
               end else begin
                  pk_store = 1'b1;
                  word_d   = src_word;
                  if (pk_would_fill) state_d = WRITE;
                  if (pend_valid_q) begin
                     pend_valid_d = 1'b0;
                     take_live    = acc_live;
                  end
               end
            end else if (end_q || fall) begin
               state_d = pk_partial ? FLUSH : DONE;
            end
         end
         WRITE, FLUSH: begin
            ram_write = 1'b1;
            pk_clear  = 1'b1;
            state_d   = (state_q == FLUSH) ? DONE : COLLECT;
            take_live = (state_q == WRITE) && acc_live && !pend_valid_q;
         end
         default: state_d = IDLE;
      endcase
      if (take_live) begin
         pend_valid_d = 1'b1;
         pend_word_d  = word_live;
         pend_lane_d  = lane_live;
         pend_data_d  = bus.ioctl_dout;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only; all next values come from _d.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= IDLE;
         dl_q         <= dl_d;
         end_q        <= 1'b0;
         pend_valid_q <= 1'b0;
         pend_word_q  <= '0;
         pend_lane_q  <= '0;
         pend_data_q  <= '0;
         word_q       <= '0;
      end else begin
         state_q      <= state_d;
         dl_q         <= dl_d;
         end_q        <= end_d;
         pend_valid_q <= pend_valid_d;
         pend_word_q  <= pend_word_d;
         pend_lane_q  <= pend_lane_d;
         pend_data_q  <= pend_data_d;
         word_q       <= word_d;
      end
   end

`ifdef DPRAM_LOADER_CHECKSUM_EN
   logic [7:0] cks_q, cks_d;

   always_comb begin
      cks_d = cks_q;
      if (enter_collect)  cks_d = 8'h00;
      else if (pk_store)  cks_d = cks_q + src_data;
   end

   always_ff @(posedge clock) begin
      if (reset) cks_q <= 8'h00;
      else       cks_q <= cks_d;
   end

   assign checksum = cks_q;
`else
   assign checksum = 8'h00;
`endif

   assign bus.ioctl_wait  = (state_q == WRITE) || (state_q == FLUSH) || pend_valid_q;
   assign bus.ram_enable  = ram_write;
   assign bus.ram_wren    = ram_write;
   assign bus.ram_address = ram_write ? word_q : '0;
   assign bus.ram_data    = ram_write ? pk_data : '0;
   assign done            = (state_q == DONE);

endmodule

// File: tb/tb_dpram_loader.sv
// Directed and randomized bench for dpram_loader (16-bit words, base 0x100, index 0).
module tb_dpram_loader;
   import dpram_loader_pkg::*;

   localparam int AW    = 8;
   localparam int DW    = 16;
   localparam int BYTES = DW / 8;
   localparam int BASE  = 'h100;
   localparam int LIMIT = 40;

   typedef struct packed {
      logic          w;
      logic          wren;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } wr_t;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       done;
   logic [7:0] checksum;
   int         n_checks = 0;
   int         n_errors = 0;

   wr_t act_q[$];
   wr_t exp_q[$];

   // Reference model state: current partially filled word of the active session.
   bit             model_live;
   bit             model_done;
   int             g_word;
   logic [DW-1:0]  g_data;
   logic [BYTES-1:0] g_mask;
   logic [7:0]     exp_cks;

   dpram_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   dpram_loader #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .BASE_ADDR  (25'h100),
      .INDEX      (8'd0)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .bus      (bus),
      .done     (done),
      .checksum (checksum)
   );

   always #5 clock = ~clock;

   always @(negedge clock)
      if (bus.ram_enable === 1'b1)
         act_q.push_back(wr_t'{bus.ioctl_wait, bus.ram_wren, bus.ram_address, bus.ram_data});

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic bound(input string tag, input int t);
      n_checks++;
      assert (t < LIMIT) else begin
         n_errors++;
         $error("FAIL %s timeout: waited %0d cycles, limit %0d", tag, t, LIMIT);
      end
   endtask

   function automatic logic [7:0] exp_checksum();
`ifdef DPRAM_LOADER_CHECKSUM_EN
      return exp_cks;
`else
      return 8'h00;
`endif
   endfunction

   task automatic model_emit();
      exp_q.push_back(wr_t'{1'b1, 1'b1, AW'(g_word), g_data});
      g_mask = '0;
      g_data = '0;
   endtask

   task automatic model_reset();
      model_live = 0;
      model_done = 0;
      g_mask     = '0;
      g_data     = '0;
      exp_cks    = 8'h00;
   endtask

   // Words are written when all lanes are filled, when a byte for another word arrives, or at end.
   task automatic model_byte(input int addr, input int data);
      int off, w, l;
      if (!(model_live && bus.ioctl_index == 8'd0 && addr >= BASE && addr < BASE + BYTES * (1 << AW)))
         return;
      off = addr - BASE;
      w   = off / BYTES;
      l   = off % BYTES;
      if (g_mask != 0 && w != g_word) model_emit();
      g_word           = w;
      g_data[8*l +: 8] = 8'(data);
      g_mask[l]        = 1'b1;
      exp_cks          = exp_cks + 8'(data);
      if (&g_mask) model_emit();
   endtask

   task automatic start_dl(input int idx);
      bus.ioctl_index    = 8'(idx);
      bus.ioctl_download = 1'b1;
      if (idx == 0) begin
         model_live = 1;
         model_done = 0;
         g_mask     = '0;
         g_data     = '0;
         exp_cks    = 8'h00;
      end
      @(negedge clock);
   endtask

   task automatic send(input int addr, input int data, input bit honour);
      int t = 0;
      if (honour) begin
         while (bus.ioctl_wait !== 1'b0 && t < LIMIT) begin
            @(negedge clock);
            t++;
         end
         bound("wait", t);
      end
      bus.ioctl_addr = 25'(addr);
      bus.ioctl_dout = 8'(data);
      bus.ioctl_wr   = 1'b1;
      @(negedge clock);
      bus.ioctl_wr   = 1'b0;
      model_byte(addr, data);
   endtask

   // Byte strobe in the same cycle the download drops.
   task automatic send_last(input int addr, input int data);
      int t = 0;
      while (bus.ioctl_wait !== 1'b0 && t < LIMIT) begin
         @(negedge clock);
         t++;
      end
      bound("wait last", t);
      bus.ioctl_addr     = 25'(addr);
      bus.ioctl_dout     = 8'(data);
      bus.ioctl_wr       = 1'b1;
      bus.ioctl_download = 1'b0;
      @(negedge clock);
      bus.ioctl_wr       = 1'b0;
      model_byte(addr, data);
   endtask

   task automatic end_dl(input bit expect_done);
      int t = 0;
      bus.ioctl_download = 1'b0;
      if (model_live) begin
         if (g_mask != 0) model_emit();
         model_done = 1;
      end
      model_live = 0;
      @(negedge clock);
      if (expect_done) begin
         while (done !== 1'b1 && t < LIMIT) begin
            @(negedge clock);
            t++;
         end
         bound("done", t);
      end
      repeat (3) @(negedge clock);
   endtask

   task automatic compare_writes(input string tag);
      check({tag, " count"}, act_q.size(), exp_q.size());
      while (act_q.size() > 0 && exp_q.size() > 0)
         check({tag, " write"}, act_q.pop_front(), exp_q.pop_front());
      act_q.delete();
      exp_q.delete();
      check({tag, " done"}, done, model_done);
      check({tag, " checksum"}, checksum, exp_checksum());
   endtask

   initial begin
      int idx, cur, a, n, r;
      bus.ioctl_download = 1'b0;
      bus.ioctl_index    = 8'd0;
      bus.ioctl_wr       = 1'b0;
      bus.ioctl_addr     = '0;
      bus.ioctl_dout     = 8'd0;
      model_reset();
      repeat (3) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);

      check("rst wait", bus.ioctl_wait, 0);
      check("rst enable", bus.ram_enable, 0);
      check("rst wren", bus.ram_wren, 0);
      check("rst address", bus.ram_address, 0);
      check("rst data", bus.ram_data, 0);
      check("rst done", done, 0);
      check("rst checksum", checksum, 0);

      // Foreign index: fully ignored.
      start_dl(1);
      send('h100, 'h5A, 1);
      send('h101, 'hA5, 1);
      end_dl(0);
      compare_writes("idx1");

      // Matching index but bytes outside the window.
      start_dl(0);
      send('h0FF, 'h77, 1);
      send(BASE + 2 * 256, 'h88, 1);
      check("window mid done", done, 0);
      check("window mid writes", act_q.size(), 0);
      end_dl(1);
      compare_writes("window");

      start_dl(0);
      send('h100, 'h11, 1);
      send('h101, 'h22, 1);
      end_dl(1);
      compare_writes("pair");

      start_dl(0);
      send('h100, 'h11, 1);
      send('h101, 'h22, 1);
      send('h102, 'h33, 1);
      end_dl(1);
      compare_writes("three");

      start_dl(0);
      send('h100, 'h11, 1);
      send('h104, 'h55, 1);
      end_dl(1);
      compare_writes("jump");

      start_dl(0);
      send('h2FE, 'hC1, 1);
      send('h2FF, 'hC2, 1);
      end_dl(1);
      compare_writes("top word");

      start_dl(0);
      send('h100, 'hAA, 1);
      send('h101, 'hBB, 1);
      send_last('h102, 'hCC);
      end_dl(1);
      compare_writes("fall strobe");

      // Strobe arriving during the write cycle must be held, not dropped.
      start_dl(0);
      send('h100, 'h01, 1);
      send('h101, 'h02, 1);
      send('h102, 'h03, 0);
      send('h103, 'h04, 1);
      end_dl(1);
      compare_writes("held strobe");

      // Reset mid-word: partial word discarded, loader idle until the next rise.
      start_dl(0);
      send('h100, 'h44, 1);
      reset = 1'b1;
      model_reset();
      repeat (2) @(negedge clock);
      check("midrst enable", bus.ram_enable, 0);
      check("midrst wait", bus.ioctl_wait, 0);
      check("midrst done", done, 0);
      check("midrst checksum", checksum, 0);
      reset = 1'b0;
      @(negedge clock);
      send('h101, 'h66, 1);
      end_dl(0);
      compare_writes("midrst");

      start_dl(0);
      send('h100, 'hFF, 1);
      send('h101, 'h02, 1);
      end_dl(1);
      compare_writes("checksum");

      for (int s = 0; s < 8; s++) begin
         idx = ($urandom_range(0, 4) == 0) ? 1 : 0;
         start_dl(idx);
         cur = BASE + $urandom_range(0, 511);
         n   = $urandom_range(4, 14);
         for (int i = 0; i < n; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
               cur = BASE + $urandom_range(0, 511);
               a   = cur;
            end else if (r == 1) begin
               a = ($urandom_range(0, 1) == 0) ? 'h0F0 + $urandom_range(0, 15) : 'h300 + $urandom_range(0, 15);
            end else begin
               cur = cur + 1;
               if (cur >= BASE + 512) cur = BASE;
               a = cur;
            end
            send(a, $urandom_range(0, 255), 1);
         end
         end_dl(idx == 0);
         compare_writes("random");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global timeout: simulation did not reach the summary");
      $fatal(1, "global timeout");
   end

endmodule
